// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and sizing helpers for the shift-add multiplier
package mult_pkg;

   typedef enum logic {IDLE, BUSY} mult_state_t;

   // The iteration counter must be able to hold the value n itself.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - control FSM and iteration counter for the shift-add multiplier
module mult_sequencer
   import mult_pkg::*;
#(
   parameter int n = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic start,
   output logic load,
   output logic add_shift,
   output logic ready
);

   localparam int cw = cnt_width(n);

   mult_state_t state;
   mult_state_t next_state;
   logic [cw-1:0] count;

   // State register; reset returns to IDLE and abandons any operation in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Iteration counter: loaded with n on accept, one step consumed per BUSY edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= cw'(n);
      end else if (add_shift) begin
         count <= count - cw'(1);
      end
   end

   // Next-state and control decode; start is only looked at while idle.
   always_comb begin
      next_state = state;
      load       = 1'b0;
      add_shift  = 1'b0;
      ready      = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               load       = 1'b1;
               next_state = BUSY;
            end
         end
         BUSY: begin
            add_shift = 1'b1;
            if (count == cw'(1)) begin
               next_state = IDLE;
            end
         end
      endcase
   end

endmodule

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential unsigned shift-and-add multiplier, one step per clock
module shift_add_multiplier
   import mult_pkg::*;
#(
   parameter int n = 8
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           start,
   input  logic [n-1:0]   M,
   input  logic [n-1:0]   Qin,
   output logic           ready,
   output logic [2*n-1:0] AQ
);

   logic         load;
   logic         add_shift;
   logic [n-1:0] m_reg;
   logic [n-1:0] a;
   logic [n-1:0] q;
   logic         c;
   logic [n:0]   sum;

   mult_sequencer #(.n(n)) u_seq (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .load      (load),
      .add_shift (add_shift),
      .ready     (ready)
   );

   // Conditional partial-product add; the (n+1)-bit sum keeps the carry-out.
   always_comb begin
      sum = {c, a} + (q[0] ? {1'b0, m_reg} : '0);
   end

   // Datapath: load operands on accept, then add-and-shift right with carry entering A's MSB.
   always_ff @(posedge clock) begin
      if (reset) begin
         m_reg <= '0;
         c     <= 1'b0;
         a     <= '0;
         q     <= '0;
      end else if (load) begin
         m_reg <= M;
         c     <= 1'b0;
         a     <= '0;
         q     <= Qin;
      end else if (add_shift) begin
         c     <= 1'b0;
         a     <= sum[n:1];
         q     <= {sum[0], q[n-1:1]};
      end
   end

   assign AQ = {a, q};

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - self-checking bench for shift_add_multiplier at n=8 and n=4
module tb_shift_add_multiplier;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  m8;
   logic [7:0]  q8;
   logic        ready8;
   logic [15:0] aq8;
   logic        start4;
   logic [3:0]  m4;
   logic [3:0]  q4;
   logic        ready4;
   logic [7:0]  aq4;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   shift_add_multiplier #(.n(8)) dut8 (
      .clock (clock),
      .reset (reset),
      .start (start),
      .M     (m8),
      .Qin   (q8),
      .ready (ready8),
      .AQ    (aq8)
   );

   shift_add_multiplier #(.n(4)) dut4 (
      .clock (clock),
      .reset (reset),
      .start (start4),
      .M     (m4),
      .Qin   (q4),
      .ready (ready4),
      .AQ    (aq4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Count negedge samples with ready low, ending on the first sample where ready is high.
   task automatic wait_ready8(output int lows);
      lows = 0;
      while (ready8 !== 1'b1 && lows < 40) begin
         lows++;
         @(negedge clock);
      end
   endtask

   task automatic wait_ready4(output int lows);
      lows = 0;
      while (ready4 !== 1'b1 && lows < 40) begin
         lows++;
         @(negedge clock);
      end
   endtask

   // Present operands with start for one edge; returns at the negedge after the accept edge.
   task automatic launch8(input logic [7:0] mm, input logic [7:0] qq);
      @(negedge clock);
      start = 1'b1;
      m8    = mm;
      q8    = qq;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic run8(input string tag, input logic [7:0] mm, input logic [7:0] qq);
      int lows;
      logic [31:0] expected;
      expected = 32'(mm) * 32'(qq);
      launch8(mm, qq);
      wait_ready8(lows);
      check({tag, "_latency"}, 32'(lows), 32'd8);
      check({tag, "_product"}, 32'(aq8), expected);
   endtask

   task automatic run4(input string tag, input logic [3:0] mm, input logic [3:0] qq);
      int lows;
      @(negedge clock);
      start4 = 1'b1;
      m4     = mm;
      q4     = qq;
      @(negedge clock);
      start4 = 1'b0;
      wait_ready4(lows);
      check({tag, "_latency"}, 32'(lows), 32'd4);
      check({tag, "_product"}, 32'(aq4), 32'(mm) * 32'(qq));
   endtask

   initial begin
      int lows;
      logic [7:0] rm;
      logic [7:0] rq;
      logic [3:0] rm4;
      logic [3:0] rq4;

      reset  = 1'b1;
      start  = 1'b0;
      start4 = 1'b0;
      m8 = '0; q8 = '0; m4 = '0; q4 = '0;
      repeat (3) @(negedge clock);
      check("reset_ready8", 32'(ready8), 32'd1);
      check("reset_aq8",    32'(aq8),    32'd0);
      check("reset_ready4", 32'(ready4), 32'd1);
      check("reset_aq4",    32'(aq4),    32'd0);
      reset = 1'b0;

      // Basic product and hold while idle.
      run8("basic", 8'h0F, 8'h0B);
      check("basic_value", 32'(aq8), 32'h00A5);
      repeat (3) @(negedge clock);
      check("hold_aq", 32'(aq8), 32'h00A5);
      check("hold_ready", 32'(ready8), 32'd1);

      // Carry path and zero operands.
      run8("ones", 8'hFF, 8'hFF);
      check("ones_value", 32'(aq8), 32'hFE01);
      run8("msb", 8'h80, 8'h02);
      check("msb_value", 32'(aq8), 32'h0100);
      run8("zero_m", 8'h00, 8'hA7);
      run8("zero_q", 8'h5A, 8'h00);

      // Start pulsed mid-operation must be ignored.
      launch8(8'h03, 8'h05);
      @(negedge clock);
      @(negedge clock);
      start = 1'b1;
      m8 = 8'hFF;
      q8 = 8'hFF;
      @(negedge clock);
      start = 1'b0;
      wait_ready8(lows);
      check("busy_latency", 32'(lows), 32'd5);
      check("busy_product", 32'(aq8), 32'h000F);
      repeat (2) @(negedge clock);
      check("busy_no_second_ready", 32'(ready8), 32'd1);
      check("busy_no_second_aq", 32'(aq8), 32'h000F);

      // Reset at edge 4 aborts the operation.
      launch8(8'hFF, 8'hFF);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("abort_ready", 32'(ready8), 32'd1);
      check("abort_aq", 32'(aq8), 32'h0000);
      @(negedge clock);
      check("abort_stays_idle", 32'(ready8), 32'd1);
      run8("after_abort", 8'h0C, 8'h0C);
      check("after_abort_value", 32'(aq8), 32'h0090);

      // Reset and start on the same edge: start dropped.
      @(negedge clock);
      reset = 1'b1;
      start = 1'b1;
      m8 = 8'h77;
      q8 = 8'h77;
      @(negedge clock);
      reset = 1'b0;
      start = 1'b0;
      check("rst_start_ready", 32'(ready8), 32'd1);
      check("rst_start_aq", 32'(aq8), 32'h0000);

      // Back-to-back with start held high.
      @(negedge clock);
      start = 1'b1;
      m8 = 8'h0F;
      q8 = 8'h0B;
      @(negedge clock);
      m8 = 8'h12;
      q8 = 8'h34;
      wait_ready8(lows);
      check("b2b_first_latency", 32'(lows), 32'd8);
      check("b2b_first_product", 32'(aq8), 32'h00A5);
      @(negedge clock);
      check("b2b_ready_one_cycle", 32'(ready8), 32'd0);
      wait_ready8(lows);
      start = 1'b0;
      check("b2b_second_latency", 32'(lows), 32'd8);
      check("b2b_second_product", 32'(aq8), 32'h03A8);
      @(negedge clock);
      check("b2b_stop", 32'(ready8), 32'd1);

      // n = 4: all-ones, then back-to-back.
      run4("n4_ones", 4'hF, 4'hF);
      check("n4_ones_value", 32'(aq4), 32'hE1);
      @(negedge clock);
      start4 = 1'b1;
      m4 = 4'hF;
      q4 = 4'hF;
      @(negedge clock);
      m4 = 4'h3;
      q4 = 4'h5;
      wait_ready4(lows);
      check("n4_b2b_first", 32'(aq4), 32'hE1);
      @(negedge clock);
      check("n4_b2b_ready_one_cycle", 32'(ready4), 32'd0);
      wait_ready4(lows);
      start4 = 1'b0;
      check("n4_b2b_latency", 32'(lows), 32'd4);
      check("n4_b2b_second", 32'(aq4), 32'h0F);

      // Randomized operands against plain multiplication.
      for (int i = 0; i < 24; i++) begin
         rm = 8'($urandom_range(0, 255));
         rq = 8'($urandom_range(0, 255));
         run8("rand8", rm, rq);
      end
      for (int i = 0; i < 12; i++) begin
         rm4 = 4'($urandom_range(0, 15));
         rq4 = 4'($urandom_range(0, 15));
         run4("rand4", rm4, rq4);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
